serial_rx: RTL
==============

# serial_rx

UART receiver, 8N1, LSB first, no parity. Companion to the existing transmitter on the same serial link (debug/host serial port). It synchronises the asynchronous `rx` pin into `clk`, detects start bits and samples each bit at mid-bit. Each received byte is presented with a one-cycle `new_data` strobe. Stop-bit violations get a one-cycle `frame_err` strobe.

## Interface
- `CLK_PER_BIT`, default 434: clk cycles per bit (50 MHz / 115200); must be ≥ 4.
- `CTR_SIZE`, default `$clog2(CLK_PER_BIT)`: bit-timer width.
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  asynchronous serial line; idle high.
- `data`  out  8  last correctly framed byte; held until the next good frame.
- `new_data`  out  1  one-cycle strobe; `data` is valid in the same cycle.
- `frame_err`  out  1  one-cycle strobe; stop bit sampled low.
- `busy`  out  1  high while a frame is in progress, i.e. state ≠ IDLE.

## Operation
- Synchroniser: two flops, `rx` → `rx_s1` → `rx_sync`. Both flops reset to 1.
- `rx_last` is `rx_sync` delayed one cycle; it resets to 1.
- A start is detected only on a falling edge: `rx_sync==0 && rx_last==1`. A line held low (break) after an error never retriggers.
- `HALF = CLK_PER_BIT/2` (integer division).
- States:
  - IDLE: `ctr=0`, `bit_ctr=0`. On start detect → START_BIT.
  - START_BIT: `ctr` increments. At `ctr==HALF-1`, sample `rx_sync` and clear `ctr`:
    - sample 0 → DATA;
    - sample 1 → false start (glitch), back to IDLE with no strobe.
  - DATA: `ctr` increments. At `ctr==CLK_PER_BIT-1`, sample `rx_sync` into `shift[bit_ctr]`, clear `ctr`, increment `bit_ctr`. After bit 7 → STOP_BIT.
  - STOP_BIT: at `ctr==CLK_PER_BIT-1`, sample `rx_sync`:
    - 1 → `data<=shift`, `new_data<=1`;
    - 0 → `frame_err<=1`, `data` unchanged.
    - Either way → IDLE.
- Returning to IDLE at mid-stop-bit allows back-to-back frames with a single stop bit.
- Strobes default to 0 every cycle. `new_data` and `frame_err` are never high together.
- Width rules: `ctr` is `CTR_SIZE` bits and never exceeds `CLK_PER_BIT-1`. `bit_ctr` is 3 bits; its wrap from 7 to 0 is intentional and unused.
- Reset (any cycle, including mid-frame):
  - state=IDLE, `ctr=0`, `bit_ctr=0`, `shift=0`;
  - outputs: `data=8'h00`, `new_data=0`, `frame_err=0`, `busy=0`;
  - sync flops=1.
  - A partial frame is discarded with no strobe.

## Timing
- Let E0 be the first clk edge after the `rx` pin falls. `rx_sync` falls at E1. State enters START_BIT at E2.
- Sample edges:
  - start bit: E2+HALF;
  - data bit i (0..7): E2+HALF+(i+1)·CLK_PER_BIT;
  - stop bit: E2+HALF+9·CLK_PER_BIT.
- `new_data`/`frame_err` are high for exactly the one cycle following the stop-sample edge. `busy` falls on that same edge.
- `busy` rises at E2.
- Start latency: 2 cycles of synchroniser delay plus 1 cycle of edge detect.
- Timing tolerance: mid-bit sampling tolerates roughly ±4 % baud mismatch accumulated over 10 bits.

## Structure
- Shared package/include `serial_pkg` holds:
  - the 2-bit state encodings IDLE=0, START_BIT=1, DATA=2, STOP_BIT=3, common with the transmitter;
  - the default `CLK_PER_BIT` constant.
- One natural sub-module, `sync_2ff`: a 1-bit two-flop synchroniser with a reset value parameter. It is reused by other async inputs.
- All other logic (FSM, counters, shift register) lives in `serial_rx`. Use registered outputs only.

## Test plan
All scenarios use `CLK_PER_BIT=16`, so `HALF=8`; the line model drives 16 cycles per bit.
- Send byte 0xA5 with a good stop bit → exactly one `new_data` pulse, with `data==8'hA5`, at E0+2+8+144 edges; `frame_err` stays 0; `busy` is high from E2 until the strobe.
- Send 0x00 then 0xFF back-to-back with 1 stop bit each → two `new_data` pulses, `data` 0x00 then 0xFF, 160 cycles apart.
- Send 0x3C with the stop bit driven low, then hold `rx` low for 40 bit times → a single `frame_err` pulse; `data` keeps its previous value; no further strobes until `rx` returns high and falls again.
- Drive a 3-cycle low glitch on idle `rx` → `busy` pulses high and returns to IDLE at the start sample; no `new_data` or `frame_err`.
- Assert `rst` for 1 cycle during data bit 4 of a frame, then send 0x81 → no strobe for the aborted frame; all outputs read 0 the cycle after reset; the next frame yields `data==8'h81`.
- Stress test: stream 256 random bytes at +3 % and −3 % baud skew → all 256 bytes received in order with no `frame_err`.

Source files
------------

// File: rtl/serial_pkg.sv
// Shared definitions for the serial link: FSM state encodings common to
// the transmitter and receiver, and the default bit period.
package serial_pkg;

    localparam int unsigned CLK_PER_BIT_DEFAULT = 434;  // 50 MHz / 115200

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA      = 2'd2,
        STOP_BIT  = 2'd3
    } serial_state_e;

endpackage : serial_pkg

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser for asynchronous inputs; both flops reset to
// RESET_VAL so the output is quiet through reset.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= RESET_VAL;
            s2_q <= RESET_VAL;
        end else begin
            s1_q <= d_i;
            s2_q <= s1_q;
        end
    end

    assign q_o = s2_q;

endmodule : sync_2ff

// File: rtl/serial_rx.sv
// 8N1 UART receiver, LSB first: synchronises rx, detects the start edge and
// samples every bit at mid-bit; one-cycle strobes for good bytes and bad stops.
module serial_rx
    import serial_pkg::*;
#(
    parameter int unsigned CLK_PER_BIT = CLK_PER_BIT_DEFAULT,
    parameter int unsigned CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       new_data,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [CTR_SIZE-1:0] HALF_LAST = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
    localparam logic [CTR_SIZE-1:0] BIT_LAST  = CTR_SIZE'(CLK_PER_BIT - 1);

    logic rx_sync;
    logic rx_last_q;

    serial_state_e       state_q, state_d;
    logic [CTR_SIZE-1:0] ctr_q, ctr_d;
    logic [2:0]          bit_ctr_q, bit_ctr_d;
    logic [7:0]          shift_q, shift_d;
    logic [7:0]          data_q, data_d;
    logic                new_data_q, new_data_d;
    logic                frame_err_q, frame_err_d;
    logic                busy_q, busy_d;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d_i (rx),
        .q_o (rx_sync)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_last_q   <= 1'b1;
            state_q     <= IDLE;
            ctr_q       <= '0;
            bit_ctr_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            new_data_q  <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            rx_last_q   <= rx_sync;
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            bit_ctr_q   <= bit_ctr_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            new_data_q  <= new_data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state, bit timer, shift register and strobe generation.
    always_comb begin
        state_d     = state_q;
        ctr_d       = ctr_q;
        bit_ctr_d   = bit_ctr_q;
        shift_d     = shift_q;
        data_d      = data_q;
        new_data_d  = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            IDLE: begin
                ctr_d     = '0;
                bit_ctr_d = '0;
                // Falling edge only, so a held-low break cannot retrigger.
                if (!rx_sync && rx_last_q) begin
                    state_d = START_BIT;
                end
            end
            START_BIT: begin
                if (ctr_q == HALF_LAST) begin
                    ctr_d   = '0;
                    state_d = rx_sync ? IDLE : DATA;
                end else begin
                    ctr_d = ctr_q + CTR_SIZE'(1);
                end
            end
            DATA: begin
                if (ctr_q == BIT_LAST) begin
                    ctr_d              = '0;
                    shift_d[bit_ctr_q] = rx_sync;
                    bit_ctr_d          = bit_ctr_q + 3'd1;
                    if (bit_ctr_q == 3'd7) begin
                        state_d = STOP_BIT;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_SIZE'(1);
                end
            end
            STOP_BIT: begin
                // Leaving at mid-stop allows back-to-back frames.
                if (ctr_q == BIT_LAST) begin
                    ctr_d   = '0;
                    state_d = IDLE;
                    if (rx_sync) begin
                        data_d     = shift_q;
                        new_data_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end else begin
                    ctr_d = ctr_q + CTR_SIZE'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    assign data      = data_q;
    assign new_data  = new_data_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule : serial_rx
